// File: rtl/bubble_buffer_load_scheduler.sv
// Fills the 2048x2 bubble output buffer from SPI flash: one burst request per
// fill, then each returned byte is unpacked MSB-first into four 2-bit writes.
//
// state  | meaning
// IDLE   | waiting for a bootloader or page trigger
// REQ    | flash_req held with address/length until flash_ack
// FETCH  | flash_byte_ready high, waiting for the next byte
// UNPACK | four consecutive buffer writes of the held byte
module bubble_buffer_load_scheduler #(
    parameter logic [23:0] BOOT_BASE  = 24'h000000,
    parameter logic [23:0] PAGE_BASE  = 24'h001000,
    parameter int          PAGE_SHIFT = 7,
    parameter int          BOOT_BYTES = 480,
    parameter int          PAGE_BYTES = 128
) (
    input  logic        master_clock,
    input  logic        reset,
    input  logic        load_bootloader,
    input  logic        load_page,
    input  logic        convert,
    input  logic [11:0] bubble_position,
    output logic        flash_req,
    output logic [23:0] flash_addr,
    output logic [8:0]  flash_len,
    input  logic        flash_ack,
    input  logic        flash_byte_valid,
    input  logic [7:0]  flash_byte,
    output logic        flash_byte_ready,
    output logic        flash_abort,
    output logic [10:0] bubble_buffer_write_address,
    output logic [1:0]  bubble_buffer_write_data_input,
    output logic        bubble_buffer_write_enable,
    output logic        busy,
    output logic        overrun
);

    typedef enum logic [1:0] {IDLE, REQ, FETCH, UNPACK} state_t;

    state_t      state_q, state_d;
    logic        lb_q, lb_d;
    logic        cv_q, cv_d;
    logic        is_page_q, is_page_d;
    logic        req_q, req_d;
    logic [23:0] addr_q, addr_d;
    logic [8:0]  len_q, len_d;
    logic [8:0]  remain_q, remain_d;
    logic        ready_q, ready_d;
    logic        abort_q, abort_d;
    logic [7:0]  shift_q, shift_d;
    logic [1:0]  phase_q, phase_d;
    logic [10:0] wa_q, wa_d;
    logic [1:0]  wd_q, wd_d;
    logic        we_q, we_d;
    logic        busy_q, busy_d;
    logic        overrun_q, overrun_d;

    logic boot_trig, page_trig, window_closed;

    always_comb begin
        state_d   = state_q;
        lb_d      = load_bootloader;
        cv_d      = convert;
        is_page_d = is_page_q;
        req_d     = req_q;
        addr_d    = addr_q;
        len_d     = len_q;
        remain_d  = remain_q;
        ready_d   = ready_q;
        abort_d   = 1'b0;
        shift_d   = shift_q;
        phase_d   = phase_q;
        wa_d      = wa_q;
        wd_d      = wd_q;
        we_d      = we_q;
        busy_d    = busy_q;
        overrun_d = overrun_q;

        boot_trig     = lb_q & ~load_bootloader;
        page_trig     = convert & ~cv_q & ~load_page;
        window_closed = is_page_q ? load_page : load_bootloader;

        if (state_q != IDLE && (boot_trig || page_trig)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (boot_trig || page_trig) begin
                    // bootloader wins a same-cycle collision; the page trigger is dropped
                    is_page_d = ~boot_trig;
                    addr_d    = boot_trig ? BOOT_BASE
                                          : PAGE_BASE + ({12'd0, bubble_position} << PAGE_SHIFT);
                    len_d     = boot_trig ? 9'(BOOT_BYTES) : 9'(PAGE_BYTES);
                    remain_d  = boot_trig ? 9'(BOOT_BYTES) : 9'(PAGE_BYTES);
                    wa_d      = 11'd0;
                    req_d     = 1'b1;
                    busy_d    = 1'b1;
                    state_d   = REQ;
                end
            end
            REQ: begin
                if (flash_ack) begin
                    req_d   = 1'b0;
                    ready_d = 1'b1;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (flash_byte_valid && ready_q) begin
                    shift_d  = flash_byte;
                    remain_d = remain_q - 9'd1;
                    ready_d  = 1'b0;
                    we_d     = 1'b0;
                    wd_d     = flash_byte[7:6];
                    phase_d  = 2'd0;
                    state_d  = UNPACK;
                end
            end
            UNPACK: begin
                wa_d = wa_q + 11'd1;
                if (phase_q == 2'd3) begin
                    we_d = 1'b1;
                    if (remain_q != 9'd0) begin
                        ready_d = 1'b1;
                        state_d = FETCH;
                    end else begin
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end
                end else begin
                    phase_d = phase_q + 2'd1;
                    wd_d    = shift_q[5:4];
                    shift_d = {shift_q[5:0], 2'b00};
                end
            end
            default: state_d = IDLE;
        endcase

        // closing the active window cancels the fill, even mid-byte
        if (state_q != IDLE && window_closed) begin
            abort_d = 1'b1;
            req_d   = 1'b0;
            ready_d = 1'b0;
            we_d    = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
        end
    end

    always_ff @(posedge master_clock) begin
        if (reset) begin
            state_q   <= IDLE;
            lb_q      <= 1'b1;
            cv_q      <= 1'b0;
            is_page_q <= 1'b0;
            req_q     <= 1'b0;
            addr_q    <= 24'd0;
            len_q     <= 9'd0;
            remain_q  <= 9'd0;
            ready_q   <= 1'b0;
            abort_q   <= 1'b0;
            shift_q   <= 8'd0;
            phase_q   <= 2'd0;
            wa_q      <= 11'd0;
            wd_q      <= 2'd0;
            we_q      <= 1'b1;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            lb_q      <= lb_d;
            cv_q      <= cv_d;
            is_page_q <= is_page_d;
            req_q     <= req_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            remain_q  <= remain_d;
            ready_q   <= ready_d;
            abort_q   <= abort_d;
            shift_q   <= shift_d;
            phase_q   <= phase_d;
            wa_q      <= wa_d;
            wd_q      <= wd_d;
            we_q      <= we_d;
            busy_q    <= busy_d;
            overrun_q <= overrun_d;
        end
    end

    assign flash_req                      = req_q;
    assign flash_addr                     = addr_q;
    assign flash_len                      = len_q;
    assign flash_byte_ready               = ready_q;
    assign flash_abort                    = abort_q;
    assign bubble_buffer_write_address    = wa_q;
    assign bubble_buffer_write_data_input = wd_q;
    assign bubble_buffer_write_enable     = we_q;
    assign busy                           = busy_q;
    assign overrun                        = overrun_q;

endmodule

// File: tb/tb_bubble_buffer_load_scheduler.sv
// Bench for bubble_buffer_load_scheduler: table of fills with random flash
// data scored against an expected write list, plus abort/reset/collision cases.
module tb_bubble_buffer_load_scheduler;

    logic        master_clock = 1'b0;
    always #5 master_clock = ~master_clock;

    logic        reset, load_bootloader, load_page, convert;
    logic [11:0] bubble_position;
    logic        flash_req, flash_ack, flash_byte_valid, flash_byte_ready, flash_abort;
    logic [23:0] flash_addr;
    logic [8:0]  flash_len;
    logic [7:0]  flash_byte;
    logic [10:0] wa;
    logic [1:0]  wd;
    logic        we, busy, overrun;

    bubble_buffer_load_scheduler dut (
        .master_clock                   (master_clock),
        .reset                          (reset),
        .load_bootloader                (load_bootloader),
        .load_page                      (load_page),
        .convert                        (convert),
        .bubble_position                (bubble_position),
        .flash_req                      (flash_req),
        .flash_addr                     (flash_addr),
        .flash_len                      (flash_len),
        .flash_ack                      (flash_ack),
        .flash_byte_valid               (flash_byte_valid),
        .flash_byte                     (flash_byte),
        .flash_byte_ready               (flash_byte_ready),
        .flash_abort                    (flash_abort),
        .bubble_buffer_write_address    (wa),
        .bubble_buffer_write_data_input (wd),
        .bubble_buffer_write_enable     (we),
        .busy                           (busy),
        .overrun                        (overrun)
    );

    typedef struct packed { logic [10:0] a; logic [1:0] d; } wr_t;
    typedef struct {
        bit          boot;
        logic [11:0] pos;
        int          bval;
        logic [23:0] exp_addr;
        logic [8:0]  exp_len;
        bit          inject;
    } vec_t;

    int   checks = 0, failures = 0;
    int   abort_count = 0, viol = 0;
    wr_t  got_q[$], exp_q[$];
    logic [7:0] byte_q[$];
    vec_t vecs[6];

    always @(negedge master_clock) begin
        if (!reset && we === 1'b0) begin
            got_q.push_back({wa, wd});
            if (busy !== 1'b1) viol++;
        end
        if (flash_abort === 1'b1) abort_count++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic trigger(input bit boot, input logic [11:0] pos);
        if (!boot) begin
            load_page = 1'b0;
            @(negedge master_clock);
        end
        @(negedge master_clock);
        if (boot) load_bootloader = 1'b0;
        else begin
            bubble_position = pos;
            convert = 1'b1;
        end
        @(negedge master_clock);
        convert = 1'b0;
        bubble_position = 12'($urandom);
        chk("req_latency", flash_req, 1);
    endtask

    task automatic ack_req();
        repeat (2) @(negedge master_clock);
        chk("req_held", flash_req, 1);
        flash_ack = 1'b1;
        @(negedge master_clock);
        flash_ack = 1'b0;
        chk("req_drop", flash_req, 0);
        chk("ready_up", flash_byte_ready, 1);
    endtask

    task automatic stream(input bit inject, input int limit);
        int idx = 0;
        int cyc = 0;
        bit inj = 1'b0;
        while (idx < byte_q.size() && cyc < limit) begin
            @(negedge master_clock);
            cyc++;
            convert = 1'b0;
            if (inject && !inj && idx >= 5) begin
                convert = 1'b1;
                inj = 1'b1;
            end
            flash_byte_valid = ($urandom_range(0, 3) != 0);
            flash_byte = byte_q[idx];
            if (flash_byte_valid && flash_byte_ready) idx++;
        end
        @(negedge master_clock);
        flash_byte_valid = 1'b0;
        convert = 1'b0;
        chk("stream_done", idx, byte_q.size());
    endtask

    task automatic wait_idle();
        int c = 0;
        while (busy === 1'b1 && c < 100) begin
            @(negedge master_clock);
            c++;
        end
        chk("idle_timeout", busy, 0);
    endtask

    task automatic do_fill(input vec_t v);
        int n = v.boot ? 480 : 128;
        int errs = 0;
        int a0 = abort_count;
        byte_q.delete();
        exp_q.delete();
        for (int i = 0; i < n; i++) byte_q.push_back(v.bval < 0 ? 8'($urandom) : v.bval[7:0]);
        for (int k = 0; k < n; k++)
            for (int j = 0; j < 4; j++) begin
                wr_t e;
                e.a = 11'((k * 4 + j) % 2048);
                e.d = 2'((byte_q[k] >> (6 - 2 * j)) & 8'd3);
                exp_q.push_back(e);
            end
        got_q.delete();
        if (v.inject) load_page = 1'b0;
        trigger(v.boot, v.pos);
        chk("flash_addr", flash_addr, v.exp_addr);
        chk("flash_len", flash_len, v.exp_len);
        chk("busy_set", busy, 1);
        ack_req();
        stream(v.inject, n * 20 + 100);
        wait_idle();
        chk("wr_count", got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            if (got_q[i] !== exp_q[i]) errs++;
        chk("wr_content", errs, 0);
        chk("overrun_flag", overrun, v.inject);
        chk("we_outside_fill", viol, 0);
        chk("no_abort", abort_count - a0, 0);
        load_bootloader = 1'b1;
        load_page = 1'b1;
        repeat (2) @(negedge master_clock);
        if (v.inject) begin
            reset = 1'b1;
            @(negedge master_clock);
            reset = 1'b0;
            @(negedge master_clock);
            chk("overrun_cleared", overrun, 0);
        end
    endtask

    initial begin
        int a0;
        int c;
        bit hit;
        vec_t clean;

        vecs[0] = '{1'b1, 12'd0,    'h1B, 24'h000000, 9'd480, 1'b0};
        vecs[1] = '{1'b0, 12'd5,    'hE4, 24'h001280, 9'd128, 1'b0};
        vecs[2] = '{1'b0, 12'd0,    -1,   24'h001000, 9'd128, 1'b0};
        vecs[3] = '{1'b0, 12'd2052, -1,   24'h041200, 9'd128, 1'b0};
        vecs[4] = '{1'b1, 12'd0,    -1,   24'h000000, 9'd480, 1'b1};
        vecs[5] = '{1'b0, 12'd1000, -1,   24'h020400, 9'd128, 1'b0};

        reset = 1'b1;
        load_bootloader = 1'b1;
        load_page = 1'b1;
        convert = 1'b0;
        bubble_position = 12'd0;
        flash_ack = 1'b0;
        flash_byte_valid = 1'b0;
        flash_byte = 8'd0;
        repeat (3) @(negedge master_clock);
        chk("rst_req", flash_req, 0);
        chk("rst_addr", flash_addr, 0);
        chk("rst_len", flash_len, 0);
        chk("rst_ready", flash_byte_ready, 0);
        chk("rst_abort", flash_abort, 0);
        chk("rst_we", we, 1);
        chk("rst_wa", wa, 0);
        chk("rst_wd", wd, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overrun", overrun, 0);
        reset = 1'b0;
        repeat (2) @(negedge master_clock);

        for (int i = 0; i < 6; i++) do_fill(vecs[i]);

        // same-cycle bootloader edge and qualified convert
        a0 = abort_count;
        got_q.delete();
        load_page = 1'b0;
        @(negedge master_clock);
        load_bootloader = 1'b0;
        convert = 1'b1;
        bubble_position = 12'd5;
        @(negedge master_clock);
        convert = 1'b0;
        chk("sim_req", flash_req, 1);
        chk("sim_addr", flash_addr, 24'h000000);
        chk("sim_len", flash_len, 9'd480);
        chk("sim_overrun", overrun, 0);
        ack_req();
        repeat (3) @(negedge master_clock);
        load_bootloader = 1'b1;
        @(negedge master_clock);
        chk("sim_abort_pulse", flash_abort, 1);
        chk("sim_busy", busy, 0);
        load_page = 1'b1;
        repeat (4) @(negedge master_clock);
        chk("sim_no_second_req", flash_req, 0);
        chk("sim_abort_count", abort_count - a0, 1);
        chk("sim_overrun_after", overrun, 0);

        // abort by load_page rising during the second write of byte 10
        a0 = abort_count;
        got_q.delete();
        trigger(1'b0, 12'd3);
        chk("abt_addr", flash_addr, 24'h001180);
        ack_req();
        hit = 1'b0;
        c = 0;
        while (!hit && c < 300) begin
            @(negedge master_clock);
            c++;
            flash_byte_valid = 1'b1;
            flash_byte = 8'($urandom);
            if (we === 1'b0 && wa === 11'd41) begin
                load_page = 1'b1;
                hit = 1'b1;
            end
        end
        chk("abt_reached", hit, 1);
        @(negedge master_clock);
        chk("abt_pulse", flash_abort, 1);
        chk("abt_busy", busy, 0);
        chk("abt_we", we, 1);
        chk("abt_ready", flash_byte_ready, 0);
        chk("abt_req", flash_req, 0);
        repeat (5) @(negedge master_clock);
        flash_byte_valid = 1'b0;
        chk("abt_count", abort_count - a0, 1);
        chk("abt_writes", got_q.size(), 42);
        chk("abt_last_addr", got_q.size() > 0 ? got_q[got_q.size() - 1].a : 11'h7FF, 41);

        // reset in the middle of an unpack
        a0 = abort_count;
        got_q.delete();
        trigger(1'b1, 12'd0);
        ack_req();
        hit = 1'b0;
        c = 0;
        while (!hit && c < 300) begin
            @(negedge master_clock);
            c++;
            flash_byte_valid = 1'b1;
            flash_byte = 8'($urandom);
            if (we === 1'b0 && wa === 11'd6) begin
                reset = 1'b1;
                hit = 1'b1;
            end
        end
        chk("rmid_reached", hit, 1);
        @(negedge master_clock);
        chk("rmid_we", we, 1);
        chk("rmid_busy", busy, 0);
        chk("rmid_wa", wa, 0);
        chk("rmid_req", flash_req, 0);
        chk("rmid_ready", flash_byte_ready, 0);
        reset = 1'b0;
        flash_byte_valid = 1'b0;
        load_bootloader = 1'b1;
        repeat (2) @(negedge master_clock);
        chk("rmid_no_abort", abort_count - a0, 0);
        clean = '{1'b0, 12'd7, -1, 24'h001380, 9'd128, 1'b0};
        do_fill(clean);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
